// File: rtl/led_seq_pkg.sv
// Shared constants for the LED sequencer: FSM encodings, switch bit positions,
// and the default prescaler periods.
package led_seq_pkg;

    localparam logic [1:0] ST_ROT  = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    localparam int SW_RUN    = 0;
    localparam int SW_SPD_LO = 1;
    localparam int SW_SPD_HI = 2;
    localparam int SW_MODE   = 3;

    localparam int COUNT_SEL0_DEF = 2**23;
    localparam int COUNT_SEL1_DEF = 2**24;
    localparam int COUNT_SEL2_DEF = 2**25;
    localparam int COUNT_SEL3_DEF = 2**26;

endpackage

// File: rtl/led_seq_controller_tick_gen.sv
// Prescaler producing a one-cycle tick every COUNT_SELn enabled clocks,
// restarting whenever the speed code changes.
module tick_gen
    import led_seq_pkg::*;
#(
    parameter int NB_COUNT   = 32,
    parameter int COUNT_SEL0 = COUNT_SEL0_DEF,
    parameter int COUNT_SEL1 = COUNT_SEL1_DEF,
    parameter int COUNT_SEL2 = COUNT_SEL2_DEF,
    parameter int COUNT_SEL3 = COUNT_SEL3_DEF
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [1:0] i_speed,
    output logic       o_tick
);

    localparam logic [NB_COUNT-1:0] LIM0 = NB_COUNT'(COUNT_SEL0 - 1);
    localparam logic [NB_COUNT-1:0] LIM1 = NB_COUNT'(COUNT_SEL1 - 1);
    localparam logic [NB_COUNT-1:0] LIM2 = NB_COUNT'(COUNT_SEL2 - 1);
    localparam logic [NB_COUNT-1:0] LIM3 = NB_COUNT'(COUNT_SEL3 - 1);

    logic [NB_COUNT-1:0] r_count;
    logic [1:0]          r_speed_prev;
    logic [NB_COUNT-1:0] w_limit;
    logic                w_speed_chg;
    logic                w_at_limit;

    always_comb begin
        w_limit = LIM0;
        case (i_speed)
            2'd0:    w_limit = LIM0;
            2'd1:    w_limit = LIM1;
            2'd2:    w_limit = LIM2;
            default: w_limit = LIM3;
        endcase
    end

    assign w_speed_chg = (i_speed != r_speed_prev);
    assign w_at_limit  = (r_count == w_limit);
    // Tick is decoded straight from the counter so it lands in the terminal cycle.
    assign o_tick      = i_enable & w_at_limit & ~w_speed_chg & ~i_reset;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_count      <= '0;
            r_speed_prev <= i_speed;
        end else begin
            r_speed_prev <= i_speed;
            if (w_speed_chg) begin
                r_count <= '0;
            end else if (i_enable) begin
                r_count <= w_at_limit ? '0 : r_count + NB_COUNT'(1);
            end
        end
    end

endmodule

// File: rtl/led_seq_controller.sv
// LED sequencer top: rotate/bounce one-hot pattern plus a blink pattern,
// both stepped by the prescaler tick.
module led_seq_controller
    import led_seq_pkg::*;
#(
    parameter int NB_LED     = 4,
    parameter int NB_COUNT   = 32,
    parameter int COUNT_SEL0 = COUNT_SEL0_DEF,
    parameter int COUNT_SEL1 = COUNT_SEL1_DEF,
    parameter int COUNT_SEL2 = COUNT_SEL2_DEF,
    parameter int COUNT_SEL3 = COUNT_SEL3_DEF
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [3:0]        i_sw,
    output logic [NB_LED-1:0] o_led_shiftreg,
    output logic [NB_LED-1:0] o_led_flash,
    output logic              o_tick,
    output logic [1:0]        o_state
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [NB_LED-1:0] r_shift;
    logic [NB_LED-1:0] w_shift_next;
    logic [NB_LED-1:0] r_flash;
    logic [NB_LED-1:0] w_rot_l;
    logic [NB_LED-1:0] w_shl;
    logic [NB_LED-1:0] w_shr;
    logic              w_tick;
    logic              w_mode;

    tick_gen #(
        .NB_COUNT  (NB_COUNT),
        .COUNT_SEL0(COUNT_SEL0),
        .COUNT_SEL1(COUNT_SEL1),
        .COUNT_SEL2(COUNT_SEL2),
        .COUNT_SEL3(COUNT_SEL3)
    ) u_tick_gen (
        .clock   (clock),
        .i_reset (i_reset),
        .i_enable(i_sw[SW_RUN]),
        .i_speed (i_sw[SW_SPD_HI:SW_SPD_LO]),
        .o_tick  (w_tick)
    );

    assign w_mode  = i_sw[SW_MODE];
    assign w_rot_l = {r_shift[NB_LED-2:0], r_shift[NB_LED-1]};
    assign w_shl   = {r_shift[NB_LED-2:0], 1'b0};
    assign w_shr   = {1'b0, r_shift[NB_LED-1:1]};

    // The step always follows the current state; a mode change wins the next-state choice.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        case (r_state)
            ST_ROT: begin
                if (w_tick) w_shift_next = w_rot_l;
                if (w_mode) w_state_next = ST_UP;
            end
            ST_UP: begin
                if (w_tick) begin
                    if (r_shift[NB_LED-1]) begin
                        w_shift_next = w_shr;
                        w_state_next = ST_DOWN;
                    end else begin
                        w_shift_next = w_shl;
                    end
                end
                if (!w_mode) w_state_next = ST_ROT;
            end
            ST_DOWN: begin
                if (w_tick) begin
                    if (r_shift[0]) begin
                        w_shift_next = w_shl;
                        w_state_next = ST_UP;
                    end else begin
                        w_shift_next = w_shr;
                    end
                end
                if (!w_mode) w_state_next = ST_ROT;
            end
            default: begin
                if (w_tick) w_shift_next = w_rot_l;
                w_state_next = ST_ROT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= ST_ROT;
            r_shift <= NB_LED'(1);
            r_flash <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            if (w_tick) r_flash <= ~r_flash;
        end
    end

    assign o_led_shiftreg = r_shift;
    assign o_led_flash    = r_flash;
    assign o_tick         = w_tick;
    assign o_state        = r_state;

endmodule
